// File: rtl/target_node_if.sv
// Bit-serial bus between a bus controller and a target endpoint.
// The controller drives the serial fields and direction; the target returns read data and status.
interface target_node_if;
   logic bus_data_in;
   logic bus_data_in_valid;
   logic bus_mode;
   logic target_rw;
   logic bus_data_out;
   logic bus_data_out_valid;
   logic bus_target_ready;
   logic bus_target_rw;
   logic bus_target_ack;

   modport master (
      output bus_data_in, bus_data_in_valid, bus_mode, target_rw,
      input  bus_data_out, bus_data_out_valid, bus_target_ready, bus_target_rw, bus_target_ack
   );

   modport slave (
      input  bus_data_in, bus_data_in_valid, bus_mode, target_rw,
      output bus_data_out, bus_data_out_valid, bus_target_ready, bus_target_rw, bus_target_ack
   );
endinterface

// File: rtl/target_node.sv
// Serial-bus target endpoint: collects a 16-bit address and an 8-bit write byte LSB-first,
// writes them into a byte memory, or returns the addressed byte serially LSB-first.
module target_node #(
   parameter int MEM_DEPTH = 256
) (
   input  logic         clk,
   input  logic         rst,
   target_node_if.slave bus
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      WRITE,
      FETCH,
      TX,
      ACK
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_sr;     // only the bits that select a location; upper address bits alias
   logic [4:0]      addr_cnt;
   logic [7:0]      data_sr;
   logic [3:0]      data_cnt;
   logic            rw_q;
   logic [7:0]      tx_sr;
   logic [2:0]      tx_cnt;
   logic            ready_q;
   logic [7:0]      mem [MEM_DEPTH];

   logic            cap_en;
   logic            cap_addr;
   logic            cap_data;
   logic            addr_last;
   logic            addr_full;
   logic            data_full;
   logic            rw_d;

   // Capture is only open while collecting a transaction; surplus bits are dropped.
   assign cap_en    = bus.bus_data_in_valid && ((state_q == IDLE) || (state_q == RX));
   assign cap_addr  = cap_en && !bus.bus_mode && (addr_cnt != 5'd16);
   assign cap_data  = cap_en &&  bus.bus_mode && (data_cnt != 4'd8);
   assign addr_last = cap_addr && (addr_cnt == 5'd15);
   assign addr_full = (addr_cnt == 5'd16) || addr_last;
   assign data_full = (data_cnt == 4'd8) || (cap_data && (data_cnt == 4'd7));
   assign rw_d      = addr_last ? bus.target_rw : rw_q;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (cap_en) state_d = RX;
         RX: begin
            if (addr_full) begin
               if (!rw_d)          state_d = FETCH;
               else if (data_full) state_d = WRITE;
            end
         end
         WRITE: state_d = IDLE;
         FETCH: state_d = TX;
         TX:    if (tx_cnt == 3'd7) state_d = ACK;
         ACK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ready_q  <= 1'b0;
         addr_sr  <= '0;
         addr_cnt <= '0;
         data_sr  <= '0;
         data_cnt <= '0;
         rw_q     <= 1'b0;
         tx_sr    <= '0;
         tx_cnt   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == IDLE);
         if (state_d == IDLE) begin
            addr_sr  <= '0;
            addr_cnt <= '0;
            data_sr  <= '0;
            data_cnt <= '0;
            rw_q     <= 1'b0;
            tx_sr    <= '0;
            tx_cnt   <= '0;
         end else begin
            if (cap_addr) begin
               for (int i = 0; i < AW; i++) begin
                  if (addr_cnt == 5'(i)) addr_sr[i] <= bus.bus_data_in;
               end
               addr_cnt <= addr_cnt + 5'd1;
            end
            if (cap_data) begin
               data_sr[data_cnt[2:0]] <= bus.bus_data_in;
               data_cnt               <= data_cnt + 4'd1;
            end
            if (addr_last) rw_q <= bus.target_rw;
            if (state_q == FETCH) begin
               tx_sr  <= mem[addr_sr];
               tx_cnt <= '0;
            end else if (state_q == TX) begin
               tx_sr  <= {1'b0, tx_sr[7:1]};
               tx_cnt <= tx_cnt + 3'd1;
            end
         end
      end
   end

   // NOTE: the memory is cleared by reset here, so it maps to flops rather than a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
      end else if (state_q == WRITE) begin
         mem[addr_sr] <= data_sr;
      end
   end

   assign bus.bus_data_out_valid = (state_q == TX);
   assign bus.bus_data_out       = (state_q == TX) && tx_sr[0];
   assign bus.bus_target_ack     = (state_q == WRITE) || (state_q == ACK);
   assign bus.bus_target_ready   = ready_q;
   assign bus.bus_target_rw      = bus.target_rw;

endmodule

// File: tb/tb_target_node.sv
// Directed bench for target_node: a transaction table of writes and reads with
// hand-computed bytes, plus reset-time and mid-read reset sequences.
module tb_target_node;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   ack_count = 0;
   logic mon_en = 1'b1;

   target_node_if bus ();

   target_node #(.MEM_DEPTH(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        junk;
      logic        noise;
      logic        data_first;
      logic [7:0]  exp;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.bus_target_ack === 1'b1) ack_count++;
         check("rw_mirror", 16'(bus.bus_target_rw), 16'(bus.target_rw));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic send_field(input logic mode, input logic [15:0] val, input int n);
      for (int i = 0; i < n; i++) begin
         bus.bus_data_in_valid = 1'b1;
         bus.bus_mode          = mode;
         bus.bus_data_in       = val[i];
         @(posedge clk); #1;
      end
      bus.bus_data_in_valid = 1'b0;
      bus.bus_mode          = 1'b0;
      bus.bus_data_in       = 1'b0;
   endtask

   task automatic wait_tx_start();
      int w = 0;
      while (bus.bus_data_out_valid !== 1'b1 && w < 6) begin
         @(posedge clk); #1;
         w++;
      end
      check("tx_start", 16'(bus.bus_data_out_valid), 16'd1);
   endtask

   task automatic run_txn(input vec_t v);
      int         a0 = ack_count;
      logic [7:0] got = '0;
      bus.target_rw = v.rw;
      if (v.rw) begin
         if (v.data_first) begin
            send_field(1'b1, {8'h00, v.wdata}, 8);
            send_field(1'b0, v.addr, 16);
         end else begin
            send_field(1'b0, v.addr, 16);
            send_field(1'b1, {8'h00, v.wdata}, 8);
         end
         check("wr_ack", 16'(bus.bus_target_ack), 16'd1);
         check("wr_ack_rw", 16'(bus.bus_target_rw), 16'd1);
         @(posedge clk); #1;
         check("wr_ack_end", 16'(bus.bus_target_ack), 16'd0);
         check("wr_ready", 16'(bus.bus_target_ready), 16'd1);
      end else begin
         if (v.junk) send_field(1'b1, 16'h00FF, 8);
         send_field(1'b0, v.addr, 16);
         check("fetch_quiet", 16'(bus.bus_data_out_valid), 16'd0);
         wait_tx_start();
         for (int i = 0; i < 8; i++) begin
            check("tx_valid", 16'(bus.bus_data_out_valid), 16'd1);
            got[i] = bus.bus_data_out;
            if (v.noise) begin
               bus.bus_data_in_valid = 1'b1;
               bus.bus_mode          = i[0];
               bus.bus_data_in       = 1'b1;
            end
            @(posedge clk); #1;
         end
         bus.bus_data_in_valid = 1'b0;
         bus.bus_mode          = 1'b0;
         bus.bus_data_in       = 1'b0;
         check("rd_byte", 16'(got), 16'(v.exp));
         check("rd_ack", 16'(bus.bus_target_ack), 16'd1);
         check("rd_ack_valid", 16'(bus.bus_data_out_valid), 16'd0);
         check("rd_ack_data", 16'(bus.bus_data_out), 16'd0);
         check("rd_ack_rw", 16'(bus.bus_target_rw), 16'd0);
         @(posedge clk); #1;
         check("rd_ack_end", 16'(bus.bus_target_ack), 16'd0);
         check("rd_ready", 16'(bus.bus_target_ready), 16'd1);
      end
      check("ack_once", 16'(ack_count - a0), 16'd1);
   endtask

   initial begin
      vec_t v;
      int   a0;
      vecs[0] = '{rw:1'b1, addr:16'h4A32, wdata:8'h9E, junk:1'b0, noise:1'b0, data_first:1'b0, exp:8'h00};
      vecs[1] = '{rw:1'b0, addr:16'h4A32, wdata:8'h00, junk:1'b0, noise:1'b0, data_first:1'b0, exp:8'h9E};
      vecs[2] = '{rw:1'b0, addr:16'h0032, wdata:8'h00, junk:1'b0, noise:1'b0, data_first:1'b0, exp:8'h9E};
      vecs[3] = '{rw:1'b0, addr:16'h0010, wdata:8'h00, junk:1'b0, noise:1'b0, data_first:1'b0, exp:8'h00};
      vecs[4] = '{rw:1'b0, addr:16'h4A32, wdata:8'h00, junk:1'b1, noise:1'b0, data_first:1'b0, exp:8'h9E};
      vecs[5] = '{rw:1'b0, addr:16'h4A32, wdata:8'h00, junk:1'b0, noise:1'b1, data_first:1'b0, exp:8'h9E};
      vecs[6] = '{rw:1'b1, addr:16'h0105, wdata:8'h5A, junk:1'b0, noise:1'b0, data_first:1'b1, exp:8'h00};
      vecs[7] = '{rw:1'b0, addr:16'h0005, wdata:8'h00, junk:1'b0, noise:1'b0, data_first:1'b0, exp:8'h5A};

      bus.bus_data_in       = 1'b0;
      bus.bus_data_in_valid = 1'b0;
      bus.bus_mode          = 1'b0;
      bus.target_rw         = 1'b0;
      rst                   = 1'b1;

      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         bus.target_rw = i[0];
      end
      check("rst_ready", 16'(bus.bus_target_ready), 16'd0);
      check("rst_ack", 16'(bus.bus_target_ack), 16'd0);
      check("rst_valid", 16'(bus.bus_data_out_valid), 16'd0);
      check("rst_data", 16'(bus.bus_data_out), 16'd0);
      rst = 1'b0;
      bus.target_rw = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", 16'(bus.bus_target_ready), 16'd1);
      check("ack_after_rst", 16'(bus.bus_target_ack), 16'd0);
      check("valid_after_rst", 16'(bus.bus_data_out_valid), 16'd0);

      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         run_txn(v);
         repeat (2) @(posedge clk);
         #1;
      end
      check("ack_total", 16'(ack_count), 16'd8);

      // Reset in the middle of a read, after three bits have been shifted out.
      bus.target_rw = 1'b0;
      send_field(1'b0, 16'h4A32, 16);
      wait_tx_start();
      repeat (2) @(posedge clk);
      #1;
      check("midrd_valid_pre", 16'(bus.bus_data_out_valid), 16'd1);
      a0 = ack_count;
      rst = 1'b1;
      #1;
      check("midrd_valid", 16'(bus.bus_data_out_valid), 16'd0);
      check("midrd_data", 16'(bus.bus_data_out), 16'd0);
      check("midrd_ack", 16'(bus.bus_target_ack), 16'd0);
      check("midrd_ready", 16'(bus.bus_target_ready), 16'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrd_ready_back", 16'(bus.bus_target_ready), 16'd1);
      check("midrd_no_ack", 16'(ack_count - a0), 16'd0);

      v = '{rw:1'b0, addr:16'h4A32, wdata:8'h00, junk:1'b0, noise:1'b0, data_first:1'b0, exp:8'h00};
      run_txn(v);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/target_node.md
Name: target_node

Overview:
- Serial-bus target endpoint: a bit-serial bus port front-end combined with a byte-wide memory target.
- Deserialises a 16-bit address and 8-bit write data arriving LSB-first on a 1-bit bus, and performs memory writes.
- For reads, returns the addressed byte serially, LSB-first.
- Signals completion with a one-cycle ack; mirrors read/write direction and readiness back to the bus side.

Parameters:
- MEM_DEPTH, 256, number of byte locations; power of two, 2..65536; memory index = address low log2(MEM_DEPTH) bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- bus_data_in  in  1  serial data bit
- bus_data_in_valid  in  1  bus_data_in carries a valid bit this cycle
- bus_mode  in  1  field select for valid bit: 0 = address bit, 1 = write-data bit
- target_rw  in  1  transaction direction: 1 = write, 0 = read
- bus_data_out  out  1  serial read-data bit
- bus_data_out_valid  out  1  bus_data_out carries a valid bit this cycle
- bus_target_ready  out  1  endpoint idle and able to accept a new transaction
- bus_target_rw  out  1  combinational copy of target_rw
- bus_target_ack  out  1  one-cycle transaction-complete pulse

Behaviour:
- Reset values (asynchronous): bus_data_out=0, bus_data_out_valid=0, bus_target_ack=0, bus_target_ready=0. All counters/shift registers=0, memory contents=0x00, state=IDLE.
- bus_target_ready rises on the first clk edge after rst deasserts.
- bus_target_rw = target_rw at all times, including during reset.
- Serial capture, LSB first:
  - Each clk edge with bus_data_in_valid=1 and bus_mode=0 stores bus_data_in into address bit [addr_cnt]; addr_cnt increments, 0..15.
  - bus_mode=1 stores into data bit [data_cnt]; data_cnt increments, 0..7.
  - The first valid bit in IDLE moves the block to RX and drops bus_target_ready on the same edge.
- Address complete: the edge capturing address bit 15 latches target_rw as the transaction direction.
- Write (latched rw=1):
  - Waits in RX until data bit 7 is captured (data bits may also precede address completion).
  - On the edge after both fields are complete (state WRITE), mem[addr index] <= data byte.
  - The same edge drives bus_target_ack=1 for exactly one cycle.
  - Next edge: back to IDLE with bus_target_ready=1.
- Read (latched rw=0):
  - Data-field bits received during RX are ignored.
  - Edge after address completion: state FETCH, byte read into an output shift register.
  - Next 8 cycles (state TX): bus_data_out_valid=1, bus_data_out = byte bit 0 first … bit 7 last.
  - Cycle after bit 7 (state ACK): bus_data_out_valid=0 and bus_target_ack=1 for one cycle.
  - Next edge: IDLE with bus_target_ready=1.
- States: IDLE → RX → WRITE → IDLE, or IDLE → RX → FETCH → TX(8 cycles) → ACK → IDLE.
- Valid input bits arriving in WRITE/FETCH/TX/ACK are ignored.
- Bits beyond the 16th address or 8th data bit in RX are ignored.
- Counters and shift registers clear on return to IDLE.
- Address bits above log2(MEM_DEPTH) are ignored (aliasing).
- bus_data_out=0 whenever bus_data_out_valid=0.
- rst asserted mid-transaction aborts it: no memory write, no ack, outputs to reset values. Memory also clears.
- bus_target_ack never asserts outside WRITE or ACK states.

Test Plan:
- Reset 5 cycles, release → ready=1 on next edge, ack=0, valid=0. Check bus_target_rw tracks target_rw every cycle.
- Write: rw=1, address 0x4A32 as 16 serial bits (mode=0), then data 0x9E as 8 bits (mode=1) → exactly one ack with rw=1, one cycle after last data bit.
- Read: rw=0, address 0x4A32 → 8 valid bits assembling 0x9E LSB-first, then exactly one ack with rw=0. Totals: 1 write ack, 1 read ack.
- Aliasing / default: read 0x0032 after the write → 0x9E. Read 0x0010 (never written) → 0x00.
- Ignored input: during read, send 8 mode=1 bits of 0xFF → returned byte unchanged. Send valid bits during TX → serial output unaffected.
- Reset mid-read (after 3 output bits) → valid drops immediately, no ack. Subsequent read of 0x4A32 returns 0x00.
